tune_sequencer: RTL and testbench

- Parametrised successor to the single-tune piezo player.
- Plays one of NUM_TUNES note sequences from an external note ROM on the differential piezo outputs.
- Supports tune select, repeat mode, abort, and busy/done status.
- Sits between the debounced go/abort pulses (from push-button release logic) and the piezo driver pins.

---
 rtl/tune_sequencer.sv | 176 +++++++++++++++++
 tb/tb_tune_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/tune_sequencer.sv
// Multi-tune piezo sequencer: walks a tune's note slots in an external ROM and
// drives a differential square-wave tone for each note's duration.
module tune_sequencer #(
  parameter int unsigned FAST_SIM  = 0,
  parameter int unsigned NUM_TUNES = 4,
  parameter int unsigned MAX_NOTES = 16,
  parameter int unsigned HP_W      = 16,
  parameter int unsigned DUR_W     = 4,
  parameter int unsigned DUR_TICK  = 1048576,
  localparam int unsigned TS_W     = (NUM_TUNES > 1) ? $clog2(NUM_TUNES) : 1,
  localparam int unsigned NI_W     = $clog2(MAX_NOTES),
  localparam int unsigned AW       = TS_W + NI_W,
  localparam int unsigned DW       = 1 + HP_W + DUR_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            go,
  input  logic            abort,
  input  logic [TS_W-1:0] tune_sel,
  input  logic            repeat_en,
  output logic [AW-1:0]   note_addr,
  input  logic [DW-1:0]   note_data,
  output logic            piezo,
  output logic            piezo_n,
  output logic            busy,
  output logic            done
);

  localparam int unsigned TICK_RAW = (FAST_SIM != 0) ? (DUR_TICK >> 4) : DUR_TICK;
  localparam int unsigned TICK     = (TICK_RAW == 0) ? 1 : TICK_RAW;
  localparam int unsigned TK_W     = (DUR_TICK > 1) ? $clog2(DUR_TICK) : 1;
  localparam int unsigned DC_W     = DUR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_PLAY  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]      state, state_d;
  logic [TS_W-1:0] tune_q, tune_d;
  logic            repeat_q, repeat_d;
  logic [NI_W-1:0] idx, idx_d;
  logic [HP_W-1:0] hp_q, hp_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic            last_q, last_d;
  logic [HP_W-1:0] tone_cnt, tone_d;
  logic [TK_W-1:0] tick_cnt, tick_d;
  logic [DC_W-1:0] dur_cnt, durc_d;
  logic            piezo_d, piezo_n_d, busy_d, done_d;
  logic [AW-1:0]   addr_d;
  logic [DC_W-1:0] dur_eff;
  logic            tick_wrap, note_end;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tune_q    <= '0;
      repeat_q  <= 1'b0;
      idx       <= '0;
      hp_q      <= '0;
      dur_q     <= '0;
      last_q    <= 1'b0;
      tone_cnt  <= '0;
      tick_cnt  <= '0;
      dur_cnt   <= '0;
      piezo     <= 1'b0;
      piezo_n   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      note_addr <= '0;
    end else begin
      state     <= state_d;
      tune_q    <= tune_d;
      repeat_q  <= repeat_d;
      idx       <= idx_d;
      hp_q      <= hp_d;
      dur_q     <= dur_d;
      last_q    <= last_d;
      tone_cnt  <= tone_d;
      tick_cnt  <= tick_d;
      dur_cnt   <= durc_d;
      piezo     <= piezo_d;
      piezo_n   <= piezo_n_d;
      busy      <= busy_d;
      done      <= done_d;
      note_addr <= addr_d;
    end
  end

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d   = state;
    tune_d    = tune_q;
    repeat_d  = repeat_q;
    idx_d     = idx;
    hp_d      = hp_q;
    dur_d     = dur_q;
    last_d    = last_q;
    tone_d    = tone_cnt;
    tick_d    = tick_cnt;
    durc_d    = dur_cnt;
    piezo_d   = piezo;
    piezo_n_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    addr_d    = note_addr;

    // A zero duration plays as a single tick
    dur_eff   = (dur_q == '0) ? DC_W'(1) : {1'b0, dur_q};
    tick_wrap = (tick_cnt == TK_W'(TICK - 1));
    note_end  = tick_wrap && (dur_cnt == dur_eff - DC_W'(1));

    case (state)
      S_IDLE: begin
        if (go && !abort) begin
          tune_d   = tune_sel;
          repeat_d = repeat_en;
          idx_d    = '0;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        last_d  = note_data[DW-1];
        hp_d    = note_data[DW-2:DUR_W];
        dur_d   = note_data[DUR_W-1:0];
        tone_d  = '0;
        tick_d  = '0;
        durc_d  = '0;
        state_d = S_PLAY;
      end
      S_PLAY: begin
        if (hp_q == '0) begin
          tone_d  = '0;
          piezo_d = 1'b0;
        end else if (tone_cnt == hp_q - HP_W'(1)) begin
          tone_d  = '0;
          piezo_d = ~piezo;
        end else begin
          tone_d = tone_cnt + HP_W'(1);
        end
        if (tick_wrap) begin
          tick_d = '0;
          durc_d = dur_cnt + DC_W'(1);
        end else begin
          tick_d = tick_cnt + TK_W'(1);
        end
        if (note_end) begin
          if (!last_q && (idx != NI_W'(MAX_NOTES - 1))) begin
            idx_d   = idx + NI_W'(1);
            state_d = S_FETCH;
          end else if (repeat_q) begin
            idx_d   = '0;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d  = S_IDLE;
      repeat_d = 1'b0;
    end

    // Tone only exists in PLAY; elsewhere both pins rest low or piezo_n is the complement
    if (state_d != S_PLAY) piezo_d = 1'b0;
    busy_d    = (state_d == S_FETCH) || (state_d == S_PLAY);
    done_d    = (state_d == S_DONE);
    piezo_n_d = busy_d ? ~piezo_d : 1'b0;
    addr_d    = {tune_d, idx_d};
  end

endmodule

// File: tb/tb_tune_sequencer.sv
// Directed bench for tune_sequencer: a slow-tick instance for sequencing and a
// FAST_SIM instance for the shortened tick.
module tb_tune_sequencer;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 21;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, go, abort, repeat_en;
  logic [1:0]    tune_sel;
  logic [AW-1:0] note_addr;
  logic [DW-1:0] note_data;
  logic          piezo, piezo_n, busy, done;

  logic          go_f, abort_f, rep_f;
  logic [1:0]    tsel_f;
  logic [AW-1:0] addr_f;
  logic [DW-1:0] data_f;
  logic          piezo_f, piezo_n_f, busy_f, done_f;

  logic [DW-1:0] rom   [64];
  logic [DW-1:0] rom_f [64];

  assign note_data = rom[note_addr];
  assign data_f    = rom_f[addr_f];

  tune_sequencer #(.FAST_SIM(0), .NUM_TUNES(4), .MAX_NOTES(16), .HP_W(16),
                   .DUR_W(4), .DUR_TICK(32)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .abort(abort), .tune_sel(tune_sel),
    .repeat_en(repeat_en), .note_addr(note_addr), .note_data(note_data),
    .piezo(piezo), .piezo_n(piezo_n), .busy(busy), .done(done));

  tune_sequencer #(.FAST_SIM(1), .NUM_TUNES(4), .MAX_NOTES(16), .HP_W(16),
                   .DUR_W(4), .DUR_TICK(32)) dut_f (
    .clk(clk), .rst_n(rst_n), .go(go_f), .abort(abort_f), .tune_sel(tsel_f),
    .repeat_en(rep_f), .note_addr(addr_f), .note_data(data_f),
    .piezo(piezo_f), .piezo_n(piezo_n_f), .busy(busy_f), .done(done_f));

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int tune;
    int busy_len;
    int notes;
    int first_addr;
  } vec_t;

  vec_t vecs[4];

  function automatic logic [DW-1:0] mk(input int last, input int hp, input int dur);
    mk = {1'(last), 16'(hp), 4'(dur)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Play one tune to completion and check length, address walk, rests and done pulse
  task automatic run_case(input vec_t v);
    int busy_cnt, changes, prev, seq_bad, rest_bad, cyc;
    @(negedge clk);
    tune_sel = 2'(v.tune); repeat_en = 1'b0; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    chk("case_busy_latency", 32'(busy), 32'd1);
    chk("case_first_addr", 32'(note_addr), 32'(v.first_addr));
    busy_cnt = 0; changes = 1; prev = int'(note_addr); seq_bad = 0; rest_bad = 0; cyc = 0;
    while (busy === 1'b1 && cyc < 2000) begin
      busy_cnt++;
      if (int'(note_addr) != prev) begin
        if (int'(note_addr) != prev + 1) seq_bad++;
        changes++;
        prev = int'(note_addr);
      end
      if (rom[note_addr][19:4] == 16'd0 && piezo !== 1'b0) rest_bad++;
      if (piezo_n !== ~piezo) rest_bad++;
      @(negedge clk);
      cyc++;
    end
    chk("case_busy_len", 32'(busy_cnt), 32'(v.busy_len));
    chk("case_note_count", 32'(changes), 32'(v.notes));
    chk("case_last_addr", 32'(prev), 32'(v.first_addr + v.notes - 1));
    chk("case_addr_seq", 32'(seq_bad), 32'd0);
    chk("case_rest_and_diff", 32'(rest_bad), 32'd0);
    chk("case_done_pulse", 32'(done), 32'd1);
    chk("case_done_quiet", 32'({piezo, piezo_n}), 32'd0);
    @(negedge clk);
    chk("case_done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    int changes, prev, done_seen, bad;

    for (int i = 0; i < 64; i++) begin
      rom[i]   = mk(1, 9, 1);
      rom_f[i] = mk(1, 9, 1);
    end
    rom[0] = mk(1, 5, 2);
    for (int i = 16; i < 32; i++) rom[i] = mk(0, 2, 1);
    rom[32] = mk(0, 3, 1);
    rom[33] = mk(0, 0, 1);
    rom[34] = mk(1, 7, 1);
    rom[48] = mk(0, 1, 1);
    rom[49] = mk(1, 1, 1);
    rom_f[0] = mk(1, 1, 3);

    vecs[0] = '{tune: 0, busy_len: 65,  notes: 1,  first_addr: 0};
    vecs[1] = '{tune: 2, busy_len: 99,  notes: 3,  first_addr: 32};
    vecs[2] = '{tune: 1, busy_len: 528, notes: 16, first_addr: 16};
    vecs[3] = '{tune: 3, busy_len: 66,  notes: 2,  first_addr: 48};

    rst_n = 1'b0; go = 1'b1; abort = 1'b0; tune_sel = 2'd1; repeat_en = 1'b0;
    go_f = 1'b0; abort_f = 1'b0; tsel_f = 2'd0; rep_f = 1'b0;

    // Reset held with go pulsing
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_outputs", 32'({piezo, piezo_n, busy, done}), 32'd0);
      chk("rst_addr", 32'(note_addr), 32'd0);
    end
    rst_n = 1'b1; go = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_no_start", 32'({busy, done}), 32'd0);

    // Single note: tone period and differential drive
    tune_sel = 2'd0; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    chk("single_fetch_busy", 32'(busy), 32'd1);
    chk("single_fetch_pins", 32'({piezo, piezo_n}), 32'b01);
    bad = 0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      chk("single_piezo", 32'(piezo), 32'(((k - 1) / 5) & 1));
      if (piezo_n !== ~piezo || busy !== 1'b1) bad++;
    end
    chk("single_diff_busy", 32'(bad), 32'd0);
    @(negedge clk);
    chk("single_done", 32'({done, busy, piezo, piezo_n}), 32'b1000);
    @(negedge clk);
    chk("single_done_once", 32'(done), 32'd0);

    for (int i = 0; i < 4; i++) run_case(vecs[i]);

    // Repeat mode alternates slots without done, then abort mid-note
    @(negedge clk);
    tune_sel = 2'd3; repeat_en = 1'b1; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    changes = 0; prev = int'(note_addr); done_seen = 0; bad = 0;
    for (int i = 0; i < 150; i++) begin
      if (int'(note_addr) != prev) begin
        changes++;
        if (int'(note_addr) != (prev == 48 ? 49 : 48)) bad++;
        prev = int'(note_addr);
      end
      if (done === 1'b1) done_seen++;
      if (busy !== 1'b1) bad++;
      @(negedge clk);
    end
    chk("repeat_wraps", 32'(changes >= 4), 32'd1);
    chk("repeat_seq_busy", 32'(bad), 32'd0);
    chk("repeat_no_done", 32'(done_seen), 32'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_quiet", 32'({busy, piezo, piezo_n, done}), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    chk("abort_stays_idle", 32'(done_seen), 32'd0);
    repeat_en = 1'b0; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    chk("restart_idx0", 32'(note_addr), 32'd48);
    chk("restart_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 200 && busy === 1'b1; i++) @(negedge clk);
    chk("restart_ends_done", 32'(done), 32'd1);

    // Reset in the middle of a tune
    @(negedge clk);
    tune_sel = 2'd1; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_outputs", 32'({busy, done, piezo, piezo_n}), 32'd0);
    chk("midrst_addr", 32'(note_addr), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_idle", 32'(busy), 32'd0);

    // FAST_SIM tick, go ignored while busy, go+abort in idle
    tsel_f = 2'd0; go_f = 1'b1;
    @(negedge clk);
    go_f = 1'b0;
    chk("fast_fetch", 32'({busy_f, piezo_f, piezo_n_f}), 32'b101);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("fast_piezo", 32'({busy_f, piezo_f}), 32'({1'b1, 1'((k - 1) & 1)}));
      go_f = (k == 2); tsel_f = (k == 2) ? 2'd1 : 2'd0;
    end
    go_f = 1'b0;
    @(negedge clk);
    chk("fast_done", 32'({done_f, busy_f}), 32'b10);
    chk("fast_addr_kept", 32'(addr_f), 32'd0);
    go_f = 1'b1; abort_f = 1'b1;
    @(negedge clk);
    go_f = 1'b0; abort_f = 1'b0;
    chk("fast_go_abort_idle", 32'({busy_f, done_f}), 32'd0);
    @(negedge clk);
    chk("fast_still_idle", 32'(busy_f), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
